// File: rtl/mem_page_pkg.sv
// Shared types for the page-memory initiator: FSM states and burst sizing.
package mem_page_pkg;

  localparam int PAGE_SIZE = 8;
  localparam int CNT_W     = $clog2(PAGE_SIZE) + 1;

  typedef logic [CNT_W-1:0] blen_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    WRITE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/mem_page_master_wbuf.sv
// Write-burst staging buffer: one write port (fill side), one async read port (issue side).
module page_wbuf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/mem_page_master.sv
// Page-memory initiator: takes one read/write burst command at a time and drives
// the responder's l_en/w_en/r_en strobes with back-to-back timing.
//
// state | meaning
// IDLE  | ready for a command
// FILL  | collecting write bytes into the buffer
// LOAD  | one cycle of l_en with the captured start address
// WRITE | len+1 cycles of w_en streaming the buffer
// READ  | len+1 cycles of r_en, bytes registered onto rd_data
// DONE  | one-cycle completion pulse (carries the last rd_valid of a read)
module mem_page_master
  import mem_page_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int PAGE_SIZE = mem_page_pkg::PAGE_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              l_en,
  output logic              w_en,
  output logic              r_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data
);

  localparam int CW    = $clog2(PAGE_SIZE) + 1;
  localparam int IDX_W = $clog2(PAGE_SIZE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  page_wbuf #(
    .DEPTH  (PAGE_SIZE),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (buf_we),
    .widx_i  (idx_q[IDX_W-1:0]),
    .wdata_i (wd_data),
    .ridx_i  (cnt_q[IDX_W-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_valid_q <= (state_q == READ);
      if (state_q == READ) rd_data_q <= r_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    buf_we    = 1'b0;
    l_en      = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    addr      = '0;
    w_data    = '0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = CW'(cmd_len);
          wr_d    = cmd_write;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = cmd_write ? FILL : LOAD;
        end
      end
      FILL: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          buf_we = 1'b1;
          idx_d  = idx_q + CW'(1);
          if (idx_q == len_q) state_d = LOAD;
        end
      end
      LOAD: begin
        l_en    = 1'b1;
        addr    = addr_q;
        state_d = wr_q ? WRITE : READ;
      end
      WRITE: begin
        w_en   = 1'b1;
        w_data = buf_rdata;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == len_q) state_d = DONE;
      end
      READ: begin
        r_en  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == len_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_page_master.sv
// Bench for mem_page_master: page-memory responder model, event monitor, and an
// array-based expected memory image driving directed and random bursts.
module tb_mem_page_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, done, l_en, w_en, r_en;
  logic [7:0] addr, w_data, r_data;

  always #5 clk = ~clk;

  mem_page_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .l_en      (l_en),
    .w_en      (w_en),
    .r_en      (r_en),
    .addr      (addr),
    .w_data    (w_data),
    .r_data    (r_data)
  );

  // Responder: EEPROM-style page write wrap, linear read advance.
  logic [7:0] mem [256];
  logic [7:0] ptr = 8'h00;
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'h00, bd_data = 8'h00;

  assign r_data = mem[ptr];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (l_en) ptr <= addr;
    else if (w_en) begin
      mem[ptr] <= w_data;
      ptr      <= {ptr[7:3], ptr[2:0] + 3'd1};
    end else if (r_en) ptr <= ptr + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       mon_clr = 1'b0;
  int         n_l, n_w, n_r, n_done, n_acc, onehot_err, busy_rdy_err;
  int         acc_cyc, done_cyc, w_first, w_last, rv_first, rv_last, last_wd_cyc;
  logic [7:0] l_addr;
  logic       done_rdv;
  logic [7:0] rdq [$];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_l = 0; n_w = 0; n_r = 0; n_done = 0; n_acc = 0;
      onehot_err = 0; busy_rdy_err = 0;
      acc_cyc = -1; done_cyc = -1; w_first = -1; w_last = -1;
      rv_first = -1; rv_last = -1; last_wd_cyc = -1;
      l_addr = 8'h00; done_rdv = 1'b0;
      rdq.delete();
    end
    if (rst_n) begin
      if (int'(l_en) + int'(w_en) + int'(r_en) > 1) onehot_err++;
      if (busy && cmd_ready) busy_rdy_err++;
      if (cmd_valid && cmd_ready) begin n_acc++; acc_cyc = cyc; end
      if (wd_valid && wd_ready) last_wd_cyc = cyc;
      if (l_en) begin n_l++; l_addr = addr; end
      if (w_en) begin
        if (n_w == 0) w_first = cyc;
        w_last = cyc;
        n_w++;
      end
      if (r_en) n_r++;
      if (rd_valid) begin
        if (rdq.size() == 0) rv_first = cyc;
        rv_last = cyc;
        rdq.push_back(rd_data);
      end
      if (done) begin n_done++; done_cyc = cyc; done_rdv = rd_valid; end
    end
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_mem [256];
  logic [7:0] wbytes [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    exp_mem[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) diffs++;
    check({tag, " mem-image"}, diffs, 0);
  endtask

  // mode: 0 = wd_valid always high, 1 = toggle 1-0-1-0, 2 = random
  task automatic run_burst(input bit wr, input logic [7:0] a, input int n, input int mode,
                           input bit extra_cmd, input string tag);
    int  i, c;
    bit  accepted;
    mon_clr   = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = 3'(n - 1);
    tick();
    mon_clr   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    if (wr) begin
      i = 0; c = 0;
      while (i < n && c < 200) begin
        wd_data = wbytes[i];
        case (mode)
          0:       wd_valid = 1'b1;
          1:       wd_valid = (c % 2 == 0);
          default: wd_valid = 1'($urandom_range(0, 1));
        endcase
        cmd_valid = extra_cmd && (c < 4);
        @(negedge clk);
        accepted = wd_valid && wd_ready;
        tick();
        if (accepted) i++;
        c++;
      end
      wd_valid  = 1'b0;
      cmd_valid = 1'b0;
      check({tag, " fill-count"}, i, n);
    end
    c = 0;
    while (n_done == 0 && c < 100) begin tick(); c++; end
    check({tag, " done-seen"}, c < 100, 1);
    tick();
    tick();
    check({tag, " accepts"}, n_acc, 1);
    check({tag, " l_en-count"}, n_l, 1);
    check({tag, " l_en-addr"}, l_addr, a);
    check({tag, " done-count"}, n_done, 1);
    check({tag, " strobe-onehot"}, onehot_err, 0);
    check({tag, " ready-while-busy"}, busy_rdy_err, 0);
    if (wr) begin
      for (int k = 0; k < n; k++) exp_mem[{a[7:3], 3'(a[2:0] + k)}] = wbytes[k];
      check({tag, " w_en-count"}, n_w, n);
      check({tag, " w_en-contiguous"}, w_last - w_first + 1, n);
      check({tag, " w_en-after-fill"}, w_first, last_wd_cyc + 2);
      check({tag, " done-after-write"}, done_cyc, w_last + 1);
      if (mode == 0) check({tag, " write-latency"}, done_cyc - acc_cyc, 2 * n + 2);
      check({tag, " no-r_en"}, n_r, 0);
    end else begin
      check({tag, " r_en-count"}, n_r, n);
      check({tag, " rd-count"}, rdq.size(), n);
      for (int k = 0; k < n && k < rdq.size(); k++)
        check($sformatf("%s rd[%0d]", tag, k), rdq[k], exp_mem[8'(a + k)]);
      check({tag, " first-rd-latency"}, rv_first - acc_cyc, 3);
      check({tag, " rd-contiguous"}, rv_last - rv_first + 1, n);
      check({tag, " read-done-latency"}, done_cyc - acc_cyc, n + 2);
      check({tag, " done-with-last-rd"}, done_rdv, 1);
      check({tag, " no-w_en"}, n_w, 0);
    end
    check_mem(tag);
  endtask

  initial begin
    logic [7:0] old28;
    int         c;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 3'd0;
    wd_valid = 1'b0; wd_data = 8'h00;
    rst_n = 1'b0;
    for (int k = 0; k < 256; k++) backdoor(8'(k), 8'($urandom));

    check("reset-ctrl", {cmd_ready, wd_ready, busy, done, rd_valid, l_en, w_en, r_en}, 8'b1000_0000);
    check("reset-data", {addr, w_data, rd_data}, 24'h0);
    rst_n = 1'b1;
    tick();

    wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
    run_burst(1'b1, 8'h10, 4, 0, 1'b0, "w4@10");
    run_burst(1'b0, 8'h10, 4, 0, 1'b0, "r4@10");

    old28 = exp_mem[8'h28];
    wbytes[0] = 8'hA1; wbytes[1] = 8'hA2; wbytes[2] = 8'hA3;
    run_burst(1'b1, 8'h26, 3, 0, 1'b0, "w3@26");
    check("pagewrap 0x26", mem[8'h26], 8'hA1);
    check("pagewrap 0x27", mem[8'h27], 8'hA2);
    check("pagewrap 0x20", mem[8'h20], 8'hA3);
    check("pagewrap 0x28", mem[8'h28], old28);

    for (int k = 0; k < 8; k++) backdoor(8'(8'hFC + k), 8'(k + 1));
    run_burst(1'b0, 8'hFC, 8, 0, 1'b0, "r8@FC");

    for (int k = 0; k < 8; k++) wbytes[k] = 8'($urandom);
    run_burst(1'b1, 8'h58, 8, 1, 1'b1, "w8-toggle");

    // Reset during the third WRITE cycle of a 5-byte burst: two bytes land.
    for (int k = 0; k < 5; k++) wbytes[k] = 8'($urandom);
    mon_clr = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 3'd4;
    tick();
    mon_clr = 1'b0; cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wd_valid = 1'b1; wd_data = wbytes[k];
      tick();
    end
    wd_valid = 1'b0;
    c = 0;
    while (n_w < 2 && c < 50) begin tick(); c++; end
    check("rst-reached-write", c < 50, 1);
    check("rst-midburst-w_en", w_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst-strobes-drop", {l_en, w_en, r_en, busy}, 4'b0000);
    check("rst-cmd_ready", cmd_ready, 1);
    exp_mem[8'h40] = wbytes[0];
    exp_mem[8'h41] = wbytes[1];
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst-ready-after", cmd_ready, 1);
    check_mem("rst-partial");
    run_burst(1'b0, 8'h40, 4, 0, 1'b0, "r4-after-rst");

    run_burst(1'b0, 8'h80, 1, 0, 1'b0, "r1@80");

    for (int t = 0; t < 12; t++) begin
      bit         wr;
      logic [7:0] a;
      int         n, mode;
      wr   = 1'($urandom_range(0, 1));
      a    = 8'($urandom);
      n    = $urandom_range(1, 8);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 8; k++) wbytes[k] = 8'($urandom);
      run_burst(wr, a, n, mode, 1'b0, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
